// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES ripple slices with
// the carry registered between slices. Operand chunks are skewed so slice k
// sees its bits k cycles after acceptance; finished low chunks ride along so
// the whole result appears together. One global enable stalls every stage.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov
);

  localparam int NS = (STAGES < 1) ? 1 : STAGES;
  localparam int W  = WIDTH / NS;

  if (STAGES < 1) begin : g_bad_stages
    $error("adder_pipe: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("adder_pipe: WIDTH must be divisible by STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] bx;
  logic             cin;

  // Subtraction is A + ~B + ~Ci, so a borrow-in of 1 means carry-in of 0.
  assign bx       = Sub ? ~B : B;
  assign cin      = Sub ? ~Ci : Ci;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && rst_n;

  for (genvar k = 0; k < NS; k++) begin : stg
    // Operand bits above this slice that still have to travel downstream.
    localparam int REM = WIDTH - (k + 1) * W;

    logic [W-1:0]         a_c;
    logic [W-1:0]         b_c;
    logic                 ci_c;
    logic                 v_in;
    logic [W:0]           sum;
    logic [(k+1)*W-1:0]   s_next;
    logic [(k+1)*W-1:0]   s_q;
    logic                 c_q;
    logic                 v_q;

    if (k == 0) begin : head
      assign a_c    = A[W-1:0];
      assign b_c    = bx[W-1:0];
      assign ci_c   = cin;
      assign v_in   = in_valid && in_ready;
      assign s_next = sum[W-1:0];
    end else begin : body
      assign a_c    = stg[k-1].fw.a_q[W-1:0];
      assign b_c    = stg[k-1].fw.b_q[W-1:0];
      assign ci_c   = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign s_next = {sum[W-1:0], stg[k-1].s_q};
    end

    assign sum = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, ci_c};

    if (REM > 0) begin : fw
      logic [REM-1:0] a_up;
      logic [REM-1:0] b_up;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : src_in
        assign a_up = A[WIDTH-1:W];
        assign b_up = bx[WIDTH-1:W];
      end else begin : src_prev
        assign a_up = stg[k-1].fw.a_q[REM+W-1:W];
        assign b_up = stg[k-1].fw.b_q[REM+W-1:W];
      end

      // Skew registers: carry the not-yet-added operand bits one stage on.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_up;
          b_q <= b_up;
        end
      end
    end

    // Slice result, carry and valid advance together under the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_next;
        c_q <= sum[W];
        v_q <= v_in;
      end
    end

    if (k == NS - 1) begin : tail
      logic ov_q;

      // Signed overflow is decided in the MSB slice, where that transaction's
      // A and Bx sign bits arrive together with the result sign bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= (a_c[W-1] == b_c[W-1]) && (sum[W-1] != a_c[W-1]);
        end
      end
    end
  end

  assign S         = stg[NS-1].s_q;
  assign Co        = stg[NS-1].c_q;
  assign Ov        = stg[NS-1].tail.ov_q;
  assign out_valid = stg[NS-1].v_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed checks on a (32,4) and an (8,1) instance,
// plus randomized streams on (32,4), (64,8) and (16,2) scored against an
// arithmetic reference model.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {ov, co, s[63:0]} for a w-bit operation, from integer arithmetic.
  function automatic logic [65:0] ref_model(input int unsigned w, input logic [63:0] a,
                                            input logic [63:0] b, input logic ci,
                                            input logic sub);
    logic [65:0] ua, ub, uc, lim, tot;
    logic signed [65:0] sa, sb, sc, st, smax, smin;
    logic [63:0] s;
    logic co, ov;
    ua  = {2'b00, a};
    ub  = {2'b00, b};
    uc  = {65'd0, ci};
    lim = 66'd1 << w;
    if (sub) begin
      co  = (ua >= ub + uc);
      tot = ua - ub - uc;
    end else begin
      tot = ua + ub + uc;
      co  = (tot >= lim);
    end
    s = tot[63:0];
    if (w < 64) s = s & ((64'd1 << w) - 64'd1);
    sa = $signed(ua);
    if (a[w-1]) sa = sa - $signed(lim);
    sb = $signed(ub);
    if (b[w-1]) sb = sb - $signed(lim);
    sc   = $signed(uc);
    st   = sub ? (sa - sb - sc) : (sa + sb + sc);
    smax = $signed(lim >> 1) - 66'sd1;
    smin = -$signed(lim >> 1);
    ov   = (st > smax) || (st < smin);
    return {ov, co, s};
  endfunction

  // Directed instances
  logic        rst_d = 1'b0;
  logic        d_iv = 1'b0, d_ir, d_ov, d_or = 1'b0, d_ci = 1'b0, d_sub = 1'b0, d_co, d_ovf;
  logic [31:0] d_a = '0, d_b = '0, d_s;
  logic        e_iv = 1'b0, e_ir, e_ov, e_or = 1'b0, e_ci = 1'b0, e_sub = 1'b0, e_co, e_ovf;
  logic [7:0]  e_a = '0, e_b = '0, e_s;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut_d (
    .clk(clk), .rst_n(rst_d), .in_valid(d_iv), .in_ready(d_ir), .A(d_a), .B(d_b),
    .Ci(d_ci), .Sub(d_sub), .out_valid(d_ov), .out_ready(d_or), .S(d_s), .Co(d_co), .Ov(d_ovf)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut_e (
    .clk(clk), .rst_n(rst_d), .in_valid(e_iv), .in_ready(e_ir), .A(e_a), .B(e_b),
    .Ci(e_ci), .Sub(e_sub), .out_valid(e_ov), .out_ready(e_or), .S(e_s), .Co(e_co), .Ov(e_ovf)
  );

  // Random-regression instances
  logic rst_r = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : rg
    localparam int WW = (g == 0) ? 32 : ((g == 1) ? 64 : 16);
    localparam int SS = (g == 0) ? 4 : ((g == 1) ? 8 : 2);
    logic          iv, ir, ov, ordy, ci, sub, co, ovf;
    logic [WW-1:0] a, b, s;
    logic          done = 1'b0;
    logic [65:0]   q[$];

    adder_pipe #(.WIDTH(WW), .STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_r), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
      .Ci(ci), .Sub(sub), .out_valid(ov), .out_ready(ordy), .S(s), .Co(co), .Ov(ovf)
    );

    initial begin
      int unsigned n_in, n_out, cyc, extra;
      logic [63:0] r1, r2;
      logic [65:0] got;
      iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      n_in = 0; n_out = 0; cyc = 0; extra = 0;
      @(posedge rst_r);
      while ((n_in < 10000 || n_out < n_in) && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        r1   = {$urandom(), $urandom()};
        r2   = {$urandom(), $urandom()};
        iv   = (n_in < 10000) && ($urandom_range(3) != 0);
        ordy = ($urandom_range(3) != 0);
        a    = r1[WW-1:0];
        b    = r2[WW-1:0];
        ci   = 1'($urandom_range(1));
        sub  = 1'($urandom_range(1));
        #1;
        chk("rnd_in_ready", {65'd0, ir}, {65'd0, (!ov || ordy)});
        if (ov) begin
          if (q.size() == 0) begin
            chk("rnd_spurious_out", 66'd1, 66'd0);
            if (ordy) n_out++;
          end else begin
            got = '0;
            got[WW-1:0] = s;
            got[64] = co;
            got[65] = ovf;
            chk("rnd_result", got, q[0]);
            if (ordy) begin
              void'(q.pop_front());
              n_out++;
            end
          end
        end
        if (iv && ir) begin
          q.push_back(ref_model(WW, 64'(a), 64'(b), ci, sub));
          n_in++;
        end
      end
      chk("rnd_count", 66'(n_out), 66'(n_in));
      chk("rnd_queue_empty", 66'(q.size()), 66'd0);
      iv = 1'b0;
      ordy = 1'b1;
      repeat (SS + 2) begin
        @(negedge clk);
        if (ov) extra++;
      end
      chk("rnd_no_extra", 66'(extra), 66'd0);
      done = 1'b1;
    end
  end

  // One isolated operation on the (32,4) unit with exact latency checks.
  task automatic one_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sub, input logic [31:0] es,
                        input logic eco, input logic eov);
    @(negedge clk);
    d_a = a; d_b = b; d_ci = ci; d_sub = sub; d_iv = 1'b1; d_or = 1'b1;
    #1 chk({tag, "_in_ready"}, {65'd0, d_ir}, 66'd1);
    @(negedge clk);
    d_iv = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_not_early"}, {65'd0, d_ov}, 66'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {65'd0, d_ov}, 66'd1);
    chk({tag, "_S"}, {34'd0, d_s}, {34'd0, es});
    chk({tag, "_Co"}, {65'd0, d_co}, {65'd0, eco});
    chk({tag, "_Ov"}, {65'd0, d_ovf}, {65'd0, eov});
  endtask

  initial begin
    int unsigned seen, acc, k, stall;
    logic started;

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_out_valid", {65'd0, d_ov}, 66'd0);
    chk("reset_in_ready", {65'd0, d_ir}, 66'd0);
    chk("reset_S", {34'd0, d_s}, 66'd0);
    repeat (2) @(negedge clk);
    rst_d = 1'b1;
    rst_r = 1'b1;

    // Directed operations
    one_op("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    one_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one_op("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Reset in mid-operation
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_a = 32'hFFFF_FFF0 + 32'(i); d_b = 32'h20; d_ci = 1'b0; d_sub = 1'b0;
      d_iv = 1'b1; d_or = 1'b1;
    end
    @(negedge clk);
    d_iv = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_valid", {65'd0, d_ov}, 66'd1);
    rst_d = 1'b0;
    #1;
    chk("rst_mid_out_valid", {65'd0, d_ov}, 66'd0);
    chk("rst_mid_S", {34'd0, d_s}, 66'd0);
    chk("rst_mid_Co", {65'd0, d_co}, 66'd0);
    chk("rst_mid_Ov", {65'd0, d_ovf}, 66'd0);
    chk("rst_mid_in_ready", {65'd0, d_ir}, 66'd0);
    repeat (2) @(negedge clk);
    rst_d = 1'b1;
    #1 chk("rst_release_in_ready", {65'd0, d_ir}, 66'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ov) seen++;
    end
    chk("rst_no_stale", 66'(seen), 66'd0);

    // Backpressure: 8 back-to-back ops, 3-cycle stall at first out_valid
    acc = 0; k = 0; stall = 0; started = 1'b0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge clk);
      if (d_ov && !started) begin
        started = 1'b1;
        stall = 3;
      end
      d_or  = (stall == 0);
      d_iv  = (acc < 8);
      d_a   = 32'(acc); d_b = 32'(acc); d_ci = 1'b0; d_sub = 1'b0;
      #1;
      chk("bp_in_ready", {65'd0, d_ir}, {65'd0, (stall == 0)});
      if (started) begin
        chk("bp_no_gap", {65'd0, d_ov}, 66'd1);
        chk("bp_S", {34'd0, d_s}, 66'(2 * k));
        if (d_or) k++;
      end
      if (d_iv && d_ir) acc++;
      if (stall > 0) stall--;
    end
    chk("bp_all_out", 66'(k), 66'd8);
    d_iv = 1'b0;
    d_or = 1'b1;

    // Parameter corner on the single-stage unit
    @(negedge clk);
    e_a = 8'hFF; e_b = 8'h01; e_ci = 1'b1; e_sub = 1'b0; e_iv = 1'b1; e_or = 1'b1;
    #1 chk("s1_in_ready", {65'd0, e_ir}, 66'd1);
    @(negedge clk);
    e_iv = 1'b0;
    chk("s1_valid", {65'd0, e_ov}, 66'd1);
    chk("s1_S", {58'd0, e_s}, 66'h01);
    chk("s1_Co", {65'd0, e_co}, 66'd1);
    chk("s1_Ov", {65'd0, e_ovf}, 66'd0);

    // Wait for the random streams, bounded
    for (int c = 0; c < 80000 && !(rg[0].done && rg[1].done && rg[2].done); c++)
      @(negedge clk);
    chk("rnd_finished", {63'd0, rg[2].done, rg[1].done, rg[0].done}, 66'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit. Splits a WIDTH-bit operation into STAGES equal chunks. Each chunk is a ripple-carry slice, and the carry is registered between slices, so one new operation is accepted per cycle at a fixed latency of STAGES cycles. It sits in the arithmetic library as the wide, high-fmax replacement for the single-cycle ripple adders. It has valid/ready flow control so it can drop into streaming datapaths.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES
- STAGES, 4, pipeline depth = number of carry slices; ≥1; violation is an elaboration error
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  unit can accept operands this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Ci  in  1  carry-in (borrow-in when Sub=1)
- Sub  in  1  0: A+B+Ci; 1: A−B−Ci
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- S  out  WIDTH  sum/difference, modulo 2^WIDTH
- Co  out  1  raw carry-out of MSB (Sub=1: 1 = no borrow)
- Ov  out  1  two's-complement signed overflow

## Operation
- Effective operands:
  - Bx = Sub ? ~B : B
  - cin = Sub ? ~Ci : Ci
  - Result = A + Bx + cin.
- Slice width W = WIDTH/STAGES. Stage k (0..STAGES−1) adds bits [k·W +: W] with the carry registered from stage k−1. Stage 0 uses cin.
- Operand skew: bits for slice k travel through k input delay registers before slice k consumes them.
- Result deskew: the low result chunks travel through delay registers so all of S aligns at the output.
- Co is the carry out of slice STAGES−1.
- Ov = (A[MSB] == Bx[MSB]) && (S[MSB] != A[MSB]), using the A and Bx that belong to the same transaction.
- Flow control uses one global advance enable: en = !out_valid || out_ready.
  - in_ready = en && rst_n.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - When en=1, every stage register (data and per-stage valid bit) shifts one stage. The stage-0 valid bit loads in_valid && in_ready.
  - When en=0, every stage holds.
- Bubbles are not collapsed; an empty stage still occupies a cycle.
- While out_valid=1 and out_ready=0, S, Co and Ov stay stable.
- Results leave in acceptance order; none is lost or duplicated.
- Reset, asynchronous on rst_n low:
  - All valid bits, data, carry and output registers go to 0: out_valid=0, S=0, Co=0, Ov=0.
  - In-flight operations are discarded.
  - in_ready=0 while rst_n is low; in_ready=1 on the first cycle after release.
- Reset in mid-operation: nothing that was in flight is emitted after release.

## Timing
- Latency: an operation accepted on edge t produces out_valid=1 after edge t+STAGES−1, so the output is sampled at edge t+STAGES. This holds when no stall occurs.
- Stalls add one cycle each.
- Throughput: 1 operation/cycle while out_ready=1.
- in_ready is combinational from out_valid, out_ready and rst_n. It has no dependency on in_valid.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and keeps the pipe full.
- STAGES=1: a single full-width ripple stage with registered outputs, latency 1.
- Critical path: one W-bit ripple plus carry register setup.

## Test plan
- Reset: stream 3 operations, pull rst_n low for 2 cycles mid-flight.
  - Immediately out_valid=0, S=0, Co=0, Ov=0, in_ready=0.
  - After release: no stale results; in_ready=1.
- Full carry ripple (WIDTH=32, STAGES=4): A=0xFFFFFFFF, B=0x00000001, Ci=0, Sub=0.
  - Exactly 4 cycles later: S=0x00000000, Co=1, Ov=0.
- Subtract and overflow:
  - A=5, B=7, Sub=1, Ci=0 → S=0xFFFFFFFE, Co=0, Ov=0.
  - A=0x7FFFFFFF, B=1, Sub=0 → S=0x80000000, Co=0, Ov=1.
  - A=0x80000000, B=1, Sub=1 → S=0x7FFFFFFF, Co=1, Ov=1.
- Backpressure: 8 back-to-back operations (A=i, B=i, i=0..7), with out_ready=0 for 3 cycles starting at the first out_valid.
  - in_ready=0 during exactly those cycles.
  - Outputs S=0,2,…,14 in order, with no gaps beyond the stall.
  - S stays stable while stalled.
- Parameter corner (WIDTH=8, STAGES=1): A=0xFF, B=0x01, Ci=1, Sub=0 → one cycle later S=0x01, Co=1, Ov=0.
- Random regression: 10k operations with random Sub/Ci, random in_valid/out_ready, run at (32,4), (64,8) and (16,2).
  - Every result matches the integer reference model in order.
  - The count of outputs equals the count of inputs.
